// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types, size encodings and helpers for the IO bus initiator
package io_bus_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYC1,
        ST_GAP,
        ST_CYC2,
        ST_RESP
    } state_t;

    // Byte count of a request; encoding 3 behaves as a 32-bit access.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_WORD: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Realign {q2,q1} to the request offset and clear bytes beyond the access size.
    function automatic logic [31:0] assemble(input logic [63:0] q,
                                             input logic [1:0]  off,
                                             input logic [2:0]  n);
        logic [31:0] sh;
        logic [31:0] m;
        sh = 32'(q >> {off, 3'b000});
        case (n)
            3'd1:    m = 32'h0000_00FF;
            3'd2:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return sh & m;
    endfunction

endpackage

// File: rtl/io_lane_align.sv
// rtl/io_lane_align.sv - byte-lane enables and write data placement for one or two bus cycles
module io_lane_align
    import io_bus_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  n,
    input  logic [31:0] wdata,
    output logic [3:0]  be1,
    output logic [3:0]  be2,
    output logic [31:0] di1,
    output logic [31:0] di2,
    output logic        split
);

    logic [3:0]  lanes;
    logic [7:0]  be_wide;
    logic [63:0] di_wide;

    // Shift the access across an 8-byte window; the upper half is the second bus cycle.
    always_comb begin
        case (n)
            3'd1:    lanes = 4'b0001;
            3'd2:    lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
        be_wide = {4'b0000, lanes} << off;
        di_wide = {32'h0, wdata} << {off, 3'b000};
        be1     = be_wide[3:0];
        be2     = be_wide[7:4];
        di1     = di_wide[31:0];
        di2     = di_wide[63:32];
        split   = |be_wide[7:4];
    end

endmodule

// File: rtl/io_bus_initiator.sv
// rtl/io_bus_initiator.sv - IO bus master with split/reassembly; optional IO_TIMEOUT_EN ready timeout
module io_bus_initiator
    import io_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int ADDR_W         = 24
)
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_a,
    output logic [3:0]        io_be,
    output logic [31:0]       io_di,
    input  logic [31:0]       io_q,
    input  logic              io_ready
);

    state_t state, state_d;

    logic              wr_q;
    logic [1:0]        off_q;
    logic [2:0]        n_q;
    logic              split_q;
    logic [3:0]        be2_q;
    logic [31:0]       di2_q;
    logic [31:0]       q1_q;
    logic [ADDR_W-3:0] word_q;

    logic              accept;
    logic [2:0]        req_n;
    logic [3:0]        be1, be2;
    logic [31:0]       di1, di2;
    logic              split;
    logic              strobe;
    logic              tmo_hit;

    logic              req_ready_d, io_rd_d, io_wr_d, rsp_valid_d, rsp_err_d;
    logic [31:0]       io_a_d, io_di_d, rsp_rdata_d;
    logic [3:0]        io_be_d;

    assign accept = req_valid & req_ready;
    assign req_n  = size_to_n(req_size);
    assign strobe = io_rd | io_wr;

    io_lane_align u_align (
        .off   (req_addr[1:0]),
        .n     (req_n),
        .wdata (req_wdata),
        .be1   (be1),
        .be2   (be2),
        .di1   (di1),
        .di2   (di2),
        .split (split)
    );

`ifdef IO_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Count strobe-high cycles of the current bus cycle, restarting on every strobe assertion.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            tmo_cnt <= '0;
        else if ((io_rd_d | io_wr_d) && !strobe)
            tmo_cnt <= '0;
        else if (strobe)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = strobe && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_d     = state;
        io_rd_d     = 1'b0;
        io_wr_d     = 1'b0;
        io_a_d      = '0;
        io_be_d     = '0;
        io_di_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CYC1;
                    io_rd_d = ~req_wr;
                    io_wr_d = req_wr;
                    io_a_d  = 32'({req_addr[ADDR_W-1:2], 2'b00});
                    io_be_d = be1;
                    io_di_d = di1;
                end
            end
            ST_CYC1: begin
                if (io_ready) begin
                    if (split_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = wr_q ? 32'h0 : assemble({32'h0, io_q}, off_q, n_q);
                    end
                end else if (tmo_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    io_rd_d = io_rd;
                    io_wr_d = io_wr;
                    io_a_d  = io_a;
                    io_be_d = io_be;
                    io_di_d = io_di;
                end
            end
            ST_GAP: begin
                state_d = ST_CYC2;
                io_rd_d = ~wr_q;
                io_wr_d = wr_q;
                io_a_d  = 32'({word_q + 1'b1, 2'b00});
                io_be_d = be2_q;
                io_di_d = di2_q;
            end
            ST_CYC2: begin
                if (io_ready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? 32'h0 : assemble({io_q, q1_q}, off_q, n_q);
                end else if (tmo_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    io_rd_d = io_rd;
                    io_wr_d = io_wr;
                    io_a_d  = io_a;
                    io_be_d = io_be;
                    io_di_d = io_di;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_a      <= '0;
            io_be     <= '0;
            io_di     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            io_rd     <= io_rd_d;
            io_wr     <= io_wr_d;
            io_a      <= io_a_d;
            io_be     <= io_be_d;
            io_di     <= io_di_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Request context on accept, and first-cycle read data for split reads.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_q    <= 1'b0;
            off_q   <= '0;
            n_q     <= '0;
            split_q <= 1'b0;
            be2_q   <= '0;
            di2_q   <= '0;
            q1_q    <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                off_q   <= req_addr[1:0];
                n_q     <= req_n;
                split_q <= split;
                be2_q   <= be2;
                di2_q   <= di2;
                word_q  <= req_addr[ADDR_W-1:2];
            end
            if (state == ST_CYC1 && io_ready)
                q1_q <= io_q;
        end
    end

endmodule
